// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async-FIFO pointer width and Gray/binary conversions
package fifo_pkg;
  localparam int ADDR_W = 3;
  localparam int PTR_W = ADDR_W + 1;
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return (b >> 1) ^ b;
  endfunction
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_read_ptr_empty_ctrl_if.sv
// fifo_read_ptr_empty_ctrl_if: read-side pointer/status bundle of the async FIFO
interface fifo_read_ptr_empty_ctrl_if #(parameter int address = 3);
  logic [address:0]   sync_write_ptr;
  logic               read_en;
  logic               underflow_clr;
  logic [address-1:0] read_addr;
  logic [address:0]   read_ptr;
  logic               empty;
  logic               almost_empty;
  logic [address:0]   read_count;
  logic               read_valid;
  logic               underflow;
  modport master (output sync_write_ptr, read_en, underflow_clr,
                  input read_addr, read_ptr, empty, almost_empty, read_count, read_valid, underflow);
  modport slave  (input sync_write_ptr, read_en, underflow_clr,
                  output read_addr, read_ptr, empty, almost_empty, read_count, read_valid, underflow);
endinterface

// File: rtl/fifo_read_ptr_empty_ctrl.sv
// fifo_read_ptr_empty_ctrl: read pointers, empty/almost-empty, fill level, underflow and read-valid
module fifo_read_ptr_empty_ctrl import fifo_pkg::*; #(
  parameter int address = ADDR_W,
  parameter int ALMOST_EMPTY_TH = 1
) (
  input logic read_clk,
  input logic read_rst_n,
  fifo_read_ptr_empty_ctrl_if.slave rif
);
  localparam int PW = address + 1;
  logic [PW-1:0] read_bin_q, read_bin_d, read_ptr_q, read_ptr_d, read_count_q, read_count_d, wbin;
  logic empty_q, empty_d, almost_empty_q, almost_empty_d, read_valid_q, read_valid_d;
  logic underflow_q, underflow_d, accept;
  // flags use next-pointer values so the last read sets empty on the same edge it advances
  always_comb begin
    accept         = rif.read_en & ~empty_q;
    read_bin_d     = read_bin_q + PW'(accept);
    read_ptr_d     = PW'(bin2gray(32'(read_bin_d)));
    wbin           = PW'(gray2bin(32'(rif.sync_write_ptr)));
    read_count_d   = wbin - read_bin_d;
    empty_d        = read_ptr_d == rif.sync_write_ptr;
    almost_empty_d = 32'(read_count_d) <= 32'(ALMOST_EMPTY_TH);
    read_valid_d   = accept;
    underflow_d    = (rif.read_en & empty_q) | (underflow_q & ~rif.underflow_clr);
  end
  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      read_bin_q     <= '0;
      read_ptr_q     <= '0;
      read_count_q   <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      read_valid_q   <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      read_bin_q     <= read_bin_d;
      read_ptr_q     <= read_ptr_d;
      read_count_q   <= read_count_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      read_valid_q   <= read_valid_d;
      underflow_q    <= underflow_d;
    end
  end
  assign rif.read_addr    = read_bin_q[address-1:0];
  assign rif.read_ptr     = read_ptr_q;
  assign rif.read_count   = read_count_q;
  assign rif.empty        = empty_q;
  assign rif.almost_empty = almost_empty_q;
  assign rif.read_valid   = read_valid_q;
  assign rif.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_read_ptr_empty_ctrl.sv
// tb_fifo_read_ptr_empty_ctrl: directed self-checking bench for the read-side controller
module tb_fifo_read_ptr_empty_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int tests = 0;
  int fails = 0;
  fifo_read_ptr_empty_ctrl_if #(.address(3)) rif ();
  fifo_read_ptr_empty_ctrl #(.address(3), .ALMOST_EMPTY_TH(1)) dut (
    .read_clk(clk), .read_rst_n(rst_n), .rif(rif.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    rif.sync_write_ptr = 4'b0010;
    rif.read_en = 1'b0;
    rif.underflow_clr = 1'b0;
    #12;
    chk("rst_empty", 32'(rif.empty), 1);
    chk("rst_count", 32'(rif.read_count), 0);
    chk("rst_ptr", 32'(rif.read_ptr), 0);
    chk("rst_valid", 32'(rif.read_valid), 0);
    chk("rst_uf", 32'(rif.underflow), 0);
    chk("rst_ae", 32'(rif.almost_empty), 1);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("fill_empty", 32'(rif.empty), 0);
    chk("fill_count", 32'(rif.read_count), 3);
    chk("fill_ae", 32'(rif.almost_empty), 0);
    rif.read_en = 1'b1;
    chk("rd0_addr", 32'(rif.read_addr), 0);
    step();
    chk("rd1_valid", 32'(rif.read_valid), 1);
    chk("rd1_count", 32'(rif.read_count), 2);
    chk("rd1_addr", 32'(rif.read_addr), 1);
    step();
    chk("rd2_count", 32'(rif.read_count), 1);
    chk("rd2_ae", 32'(rif.almost_empty), 1);
    chk("rd2_addr", 32'(rif.read_addr), 2);
    chk("rd2_empty", 32'(rif.empty), 0);
    step();
    chk("rd3_empty", 32'(rif.empty), 1);
    chk("rd3_count", 32'(rif.read_count), 0);
    chk("rd3_ptr", 32'(rif.read_ptr), 32'b0010);
    chk("rd3_valid", 32'(rif.read_valid), 1);
    rif.read_en = 1'b0;
    step();
    chk("idle_valid", 32'(rif.read_valid), 0);
    rif.read_en = 1'b1;
    step();
    chk("uf_set", 32'(rif.underflow), 1);
    chk("uf_ptr", 32'(rif.read_ptr), 32'b0010);
    chk("uf_addr", 32'(rif.read_addr), 3);
    chk("uf_valid", 32'(rif.read_valid), 0);
    chk("uf_count", 32'(rif.read_count), 0);
    rif.read_en = 1'b0;
    rif.underflow_clr = 1'b1;
    step();
    chk("uf_clr", 32'(rif.underflow), 0);
    rif.read_en = 1'b1;
    step();
    chk("uf_set_wins", 32'(rif.underflow), 1);
    rif.read_en = 1'b0;
    rif.underflow_clr = 1'b0;
    #3 rst_n = 1'b0;
    rif.sync_write_ptr = 4'b1100;
    #1;
    chk("arst_uf", 32'(rif.underflow), 0);
    chk("arst_ptr", 32'(rif.read_ptr), 0);
    chk("arst_empty", 32'(rif.empty), 1);
    @(negedge clk) rst_n = 1'b1;
    step();
    chk("wrap_count", 32'(rif.read_count), 8);
    chk("wrap_empty0", 32'(rif.empty), 0);
    chk("wrap_ae0", 32'(rif.almost_empty), 0);
    rif.read_en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("wrap_addr%0d", k - 1), 32'(rif.read_addr), 32'(k - 1));
      step();
      chk($sformatf("wrap_count%0d", k), 32'(rif.read_count), 32'(8 - k));
      chk($sformatf("wrap_empty%0d", k), 32'(rif.empty), 32'(k == 8));
      chk($sformatf("wrap_valid%0d", k), 32'(rif.read_valid), 1);
    end
    chk("wrap_addr_end", 32'(rif.read_addr), 0);
    chk("wrap_ptr_end", 32'(rif.read_ptr), 32'b1100);
    rif.read_en = 1'b0;
    rif.sync_write_ptr = 4'b1101;
    step();
    chk("wr_arrive_empty", 32'(rif.empty), 0);
    chk("wr_arrive_count", 32'(rif.read_count), 1);
    rif.read_en = 1'b1;
    rif.sync_write_ptr = 4'b1111;
    step();
    chk("simul_empty", 32'(rif.empty), 0);
    chk("simul_count", 32'(rif.read_count), 1);
    chk("simul_ptr", 32'(rif.read_ptr), 32'b1101);
    rif.read_en = 1'b0;
    step();
    chk("simul_idle_empty", 32'(rif.empty), 0);
    chk("simul_idle_valid", 32'(rif.read_valid), 0);
    rif.read_en = 1'b1;
    step();
    chk("last_valid", 32'(rif.read_valid), 1);
    chk("last_empty", 32'(rif.empty), 1);
    rif.read_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("inflight_valid", 32'(rif.read_valid), 0);
    chk("inflight_count", 32'(rif.read_count), 0);
    chk("inflight_ptr", 32'(rif.read_ptr), 0);
    chk("inflight_addr", 32'(rif.read_addr), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_read_ptr_empty_ctrl.md
Name: fifo_read_ptr_empty_ctrl

Overview:
- Read-domain pointer and status controller of the async FIFO.
- Consumes the Gray write pointer produced by the write-pointer-to-read-clock synchronizer.
- Owns the binary and Gray read pointers, drives the read address into the dual-port RAM, and generates registered empty, almost-empty, fill level, underflow and read-valid.
- Its Gray read pointer is exported to the read-pointer-to-write-clock synchronizer.

Parameters:
- address, 3: RAM address width; depth = 2**address; pointers are address+1 bits.
- ALMOST_EMPTY_TH, 1: almost_empty asserts when fill level <= this value; range 0..2**address.

Ports:
- read_clk  input  1  read-domain clock; all state on its rising edge.
- read_rst_n  input  1  asynchronous, active-low reset.
- sync_write_ptr  input  address+1  Gray write pointer, already two-flop synchronized into read_clk.
- read_en  input  1  read request from the consumer.
- underflow_clr  input  1  clears the sticky underflow flag.
- read_addr  output  address  RAM read address = read_bin[address-1:0].
- read_ptr  output  address+1  registered Gray read pointer, to the write-side synchronizer.
- empty  output  1  registered empty flag.
- almost_empty  output  1  registered; fill level <= ALMOST_EMPTY_TH.
- read_count  output  address+1  registered fill level, 0..2**address.
- read_valid  output  1  RAM data valid this cycle; one-cycle latency after an accepted read.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (asynchronous on read_rst_n low, released synchronously by design):
  - read_bin=0, read_ptr=0, read_addr=0.
  - empty=1, almost_empty=1, read_count=0.
  - read_valid=0, underflow=0.
- Read acceptance:
  - accept = read_en & ~empty, using the registered empty.
  - read_bin_next = read_bin + accept, modulo 2**(address+1). The MSB is the wrap bit.
  - read_gray_next = (read_bin_next >> 1) ^ read_bin_next. Registered into read_ptr; no combinational path to read_ptr.
- Empty:
  - empty <= (read_gray_next == sync_write_ptr).
  - Recomputed every cycle, including cycles with no read, so new writes clear empty one read_clk edge after sync_write_ptr changes.
  - The last accepted read sets empty on the same edge that advances the pointer.
- Fill level:
  - wbin = Gray-to-binary of sync_write_ptr (combinational XOR-prefix from the MSB).
  - read_count <= (wbin - read_bin_next) modulo 2**(address+1).
  - almost_empty <= (that value <= ALMOST_EMPTY_TH).
  - empty and read_count are consistent: empty=1 iff read_count=0.
  - Both flags are pessimistic: they may lag writes by the synchronizer delay, never reads.
- read_valid:
  - read_valid <= accept, so it pulses for exactly one cycle per accepted read.
  - RAM data for read_addr sampled at edge N is valid while read_valid=1 after edge N+1.
- Underflow:
  - Set when read_en & empty.
  - Cleared by underflow_clr.
  - Simultaneous set and clear: set wins.
  - An underflowing read leaves pointers, read_valid and read_count unchanged.
- Wrap-around:
  - read_addr wraps from 2**address-1 to 0 while read_bin MSB toggles.
  - Full level (read_count = 2**address) is representable; read_ptr and sync_write_ptr then differ in their top two bits.
- Reset mid-operation:
  - All outputs go to reset values immediately, with no dependence on read_clk.
  - An in-flight read_valid is dropped.

Decomposition:
- Shared package fifo_pkg holds:
  - the pointer-width constant (address+1);
  - bin2gray and gray2bin functions, shared with the write-side full controller.
- No sub-module. The Gray conversions are package functions; the synchronizer stays a separate sibling instance.

Test Plan:
- Reset with read_rst_n=0 mid-clock and sync_write_ptr=4'b0010 -> outputs asynchronously go to empty=1, read_count=0, read_ptr=0, read_valid=0, underflow=0.
- After reset release, sync_write_ptr=4'b0010 (bin 3), no reads -> next edge empty=0, read_count=3, almost_empty=0 (TH=1).
- Three back-to-back reads:
  - read_addr 0,1,2 on successive edges;
  - read_valid high for 3 cycles, each one cycle late;
  - after the 2nd read read_count=1 and almost_empty=1;
  - after the 3rd read empty=1, read_count=0, read_ptr=4'b0010.
- read_en=1 while empty -> underflow=1, pointers unchanged, read_valid=0.
  - underflow_clr alone -> underflow=0.
  - underflow_clr with read_en on an empty FIFO -> underflow stays 1.
- Wrap: start from read_bin=0 with sync_write_ptr=4'b1100 (bin 8) -> read_count=8.
  - Eight reads -> read_addr 0..7 then back to 0, read_ptr=4'b1100, empty=1.
  - No spurious empty before the 8th read.
- Simultaneous write arrival and last read: sync_write_ptr advances by 1 on the edge where the final read is accepted -> empty stays 0 the following cycle and read_count=1.
